// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, coefficient indices and round/saturate helper for the biquad cascade
package iir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

    typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_ADD, OP_SUB} mac_op_t;

    localparam int COEFS_PER_STAGE = 5;

    localparam logic [2:0] K_A0 = 3'd0;
    localparam logic [2:0] K_A1 = 3'd1;
    localparam logic [2:0] K_A2 = 3'd2;
    localparam logic [2:0] K_B1 = 3'd3;
    localparam logic [2:0] K_B2 = 3'd4;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] value;
    } rs_t;

    // Round half toward +inf by adding half an LSB before the arithmetic shift,
    // then clamp to the signed data_w range and report whether clamping happened.
    function automatic rs_t round_sat(input logic signed [63:0] acc,
                                      input int frac,
                                      input int data_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rs_t                res;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        res.sat = 1'b1;
        if (r > hi) begin
            res.value = hi;
        end else if (r < lo) begin
            res.value = lo;
        end else begin
            res.sat   = 1'b0;
            res.value = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/iir_mac.sv
// rtl/iir_mac.sv - shared multiply-accumulate unit with rounded, saturated result
import iir_pkg::*;

module iir_mac #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 12,
    parameter int ACC_W     = DATA_W + COEF_W + 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  mac_op_t                  i_op,
    input  logic signed [COEF_W-1:0] i_coef,
    input  logic signed [DATA_W-1:0] i_data,
    output logic signed [DATA_W-1:0] o_result,
    output logic                     o_sat
);

    localparam int PROD_W = COEF_W + DATA_W;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  r_acc;
    rs_t                      w_rs;

    // Full-width signed product, then sign-extended into the accumulator width
    assign w_prod     = PROD_W'(i_coef) * PROD_W'(i_data);
    assign w_prod_ext = ACC_W'(w_prod);

    // Accumulator: load on the first tap, add feed-forward taps, subtract feedback taps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            case (i_op)
                OP_LOAD: r_acc <= w_prod_ext;
                OP_ADD:  r_acc <= r_acc + w_prod_ext;
                OP_SUB:  r_acc <= r_acc - w_prod_ext;
                default: r_acc <= r_acc;
            endcase
        end
    end

    assign w_rs     = round_sat(64'(r_acc), COEF_FRAC, DATA_W);
    assign o_result = DATA_W'(w_rs.value);
    assign o_sat    = w_rs.sat;

endmodule

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - time-multiplexed cascade of Direct-Form-I biquad sections
import iir_pkg::*;

module iir_biquad_cascade #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 12,
    parameter int N_STAGES  = 2,
    parameter int ACC_W     = DATA_W + COEF_W + 4,
    localparam int ADDR_W   = $clog2(COEFS_PER_STAGE * N_STAGES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    input  logic                     coef_we,
    input  logic [ADDR_W-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     sat_clr,
    output logic                     sat_flag
);

    localparam int STG_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int NC    = COEFS_PER_STAGE * N_STAGES;
    localparam logic signed [COEF_W-1:0] A0_ONE = COEF_W'(1 << COEF_FRAC);
    localparam logic [ADDR_W:0]          NC_V   = (ADDR_W + 1)'(NC);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [2:0]               r_k;
    logic [STG_W-1:0]         r_stage;
    logic signed [DATA_W-1:0] r_x;
    logic signed [DATA_W-1:0] r_x1 [N_STAGES];
    logic signed [DATA_W-1:0] r_x2 [N_STAGES];
    logic signed [DATA_W-1:0] r_y1 [N_STAGES];
    logic signed [DATA_W-1:0] r_y2 [N_STAGES];
    logic signed [COEF_W-1:0] r_coef [NC];
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_sat_flag;

    logic                     w_in_ready;
    logic                     w_last;
    logic                     w_coef_wr;
    mac_op_t                  w_mac_op;
    logic [ADDR_W-1:0]        w_cidx;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [DATA_W-1:0] w_opnd;
    logic signed [DATA_W-1:0] w_mac_result;
    logic                     w_mac_sat;

    assign w_last    = (r_stage == STG_W'(N_STAGES - 1));
    assign w_coef_wr = coef_we && w_in_ready && ({1'b0, coef_addr} < NC_V);
    assign w_cidx    = ADDR_W'(int'(r_stage) * COEFS_PER_STAGE + int'(r_k));
    assign w_coef    = r_coef[w_cidx];

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sat_flag  = r_sat_flag;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, ready and MAC opcode per tap
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_mac_op     = OP_HOLD;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = MAC;
                end
            end
            MAC: begin
                case (r_k)
                    K_A0:       w_mac_op = OP_LOAD;
                    K_A1, K_A2: w_mac_op = OP_ADD;
                    default:    w_mac_op = OP_SUB;
                endcase
                if (r_k == K_B2) begin
                    w_next_state = STORE;
                end
            end
            STORE:   w_next_state = w_last ? DONE : MAC;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Data operand for the current tap of the current stage
    always_comb begin
        w_opnd = r_x;
        case (r_k)
            K_A0:    w_opnd = r_x;
            K_A1:    w_opnd = r_x1[r_stage];
            K_A2:    w_opnd = r_x2[r_stage];
            K_B1:    w_opnd = r_y1[r_stage];
            default: w_opnd = r_y2[r_stage];
        endcase
    end

    iir_mac #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_op     (w_mac_op),
        .i_coef   (w_coef),
        .i_data   (w_opnd),
        .o_result (w_mac_result),
        .o_sat    (w_mac_sat)
    );

    // Tap/stage sequencing; r_x carries the input of the stage being computed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_stage <= '0;
            r_x     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_data;
                        r_stage <= '0;
                        r_k     <= '0;
                    end
                end
                MAC: begin
                    r_k <= (r_k == K_B2) ? 3'd0 : r_k + 3'd1;
                end
                STORE: begin
                    r_x <= w_mac_result;
                    if (!w_last) begin
                        r_stage <= r_stage + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Per-stage x/y delay lines, shifted when the stage result is stored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_STAGES; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else if (r_state == STORE) begin
            r_x2[r_stage] <= r_x1[r_stage];
            r_x1[r_stage] <= r_x;
            r_y2[r_stage] <= r_y1[r_stage];
            r_y1[r_stage] <= w_mac_result;
        end
    end

    // Coefficient file: passthrough after reset, writable only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                r_coef[i] <= (i % COEFS_PER_STAGE == 0) ? A0_ONE : '0;
            end
        end else if (w_coef_wr) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    // Output register and one-cycle valid pulse after the final stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= (r_state == DONE);
            if (r_state == DONE) begin
                r_out_data <= r_x;
            end
        end
    end

    // Sticky saturation flag; a new saturation beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_flag <= 1'b0;
        end else if ((r_state == STORE) && w_mac_sat) begin
            r_sat_flag <= 1'b1;
        end else if (sat_clr) begin
            r_sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb/tb_iir_biquad_cascade.sv - self-checking bench for the biquad cascade
module tb_iir_biquad_cascade;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic signed [15:0] coef_wdata;
    logic              sat_clr;
    logic              sat_flag;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_out = 0;
    int last_out = 0;
    bit accepted = 0;
    bit msat = 0;
    int m_coef [10];
    int m_x1 [2];
    int m_x2 [2];
    int m_y1 [2];
    int m_y2 [2];
    int exp_q [$];
    int exp_t [$];
    int acc_cyc [$];

    iir_biquad_cascade dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .sat_clr    (sat_clr),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_coef[i] = (i % 5 == 0) ? 4096 : 0;
        for (int s = 0; s < 2; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
        msat = 0;
        exp_q.delete();
        exp_t.delete();
    endtask

    task automatic model_sample(input int x, output int y);
        int v;
        longint acc, num, r;
        v = x;
        for (int s = 0; s < 2; s++) begin
            acc = longint'(m_coef[5*s]) * v + longint'(m_coef[5*s+1]) * m_x1[s]
                + longint'(m_coef[5*s+2]) * m_x2[s] - longint'(m_coef[5*s+3]) * m_y1[s]
                - longint'(m_coef[5*s+4]) * m_y2[s];
            num = acc + 2048;
            r = num / 4096;
            if (num < 0 && (num % 4096) != 0) r = r - 1;
            if (r > 127) begin r = 127; msat = 1; end
            else if (r < -128) begin r = -128; msat = 1; end
            m_x2[s] = m_x1[s]; m_x1[s] = v;
            m_y2[s] = m_y1[s]; m_y1[s] = int'(r);
            v = int'(r);
        end
        y = v;
    endtask

    task automatic step();
        int y;
        if (rst) begin
            model_reset();
        end else begin
            if (coef_we && in_ready && coef_addr < 4'd10) m_coef[coef_addr] = int'(coef_wdata);
            if (sat_clr && in_ready) msat = 0;
            if (in_valid && in_ready) begin
                model_sample(int'(in_data), y);
                exp_q.push_back(y);
                exp_t.push_back(cyc + 14);
                acc_cyc.push_back(cyc);
                accepted = 1;
            end
        end
        @(negedge clk);
        cyc++;
        if (out_valid === 1'b1) begin
            n_out++;
            last_out = int'(out_data);
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
                chk("latency", cyc, exp_t.pop_front());
                chk("sat_flag_at_out", sat_flag, msat);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; coef_we = 0; sat_clr = 0;
        step(); step();
        rst = 0;
        step();
    endtask

    task automatic wcoef(input int a, input int v);
        coef_we = 1; coef_addr = 4'(a); coef_wdata = 16'(v);
        step();
        coef_we = 0;
    endtask

    task automatic accept(input int x);
        in_valid = 1; in_data = 8'(x); accepted = 0;
        for (int i = 0; i < 60 && !accepted; i++) step();
        in_valid = 0;
        chk("accept_timeout", accepted, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic send(input int x);
        accept(x);
        drain();
    endtask

    initial begin
        int n;
        rst = 1; in_valid = 0; in_data = 0; coef_we = 0; coef_addr = 0; coef_wdata = 0; sat_clr = 0;

        // reset state and passthrough
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat_flag", sat_flag, 0);
        send(37);   chk("pass_37", last_out, 37);
        send(-100); chk("pass_m100", last_out, -100);
        chk("pass_sat", sat_flag, 0);

        // FIR impulse
        do_reset();
        wcoef(0, 1024); wcoef(1, 2048); wcoef(2, 1024);
        send(100); chk("fir0", last_out, 25);
        send(0);   chk("fir1", last_out, 50);
        send(0);   chk("fir2", last_out, 25);
        send(0);   chk("fir3", last_out, 0);

        // first-order feedback
        do_reset();
        wcoef(3, -2048);
        send(64); chk("fb0", last_out, 64);
        send(0);  chk("fb1", last_out, 32);
        send(0);  chk("fb2", last_out, 16);
        send(0);  chk("fb3", last_out, 8);
        send(0);  chk("fb4", last_out, 4);

        // rounding
        do_reset();
        wcoef(0, 2048);
        send(3);  chk("round_p3", last_out, 2);
        send(-3); chk("round_m3", last_out, -1);
        send(1);  chk("round_p1", last_out, 1);

        // saturation and sticky flag
        do_reset();
        wcoef(0, 16384);
        send(100);  chk("sat_pos", last_out, 127); chk("sat_flag_set", sat_flag, 1);
        send(-100); chk("sat_neg", last_out, -128);
        sat_clr = 1; step(); sat_clr = 0;
        chk("sat_clr", sat_flag, 0);
        accept(100);
        for (int i = 0; i < 5; i++) step();
        sat_clr = 1; step(); sat_clr = 0;
        chk("sat_set_wins", sat_flag, 1);
        drain();

        // held in_valid: one acceptance per 14 cycles
        do_reset();
        acc_cyc.delete();
        in_valid = 1; in_data = 8'sd5;
        for (int i = 0; i < 40; i++) step();
        in_valid = 0;
        drain();
        chk("hold_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() >= 3) begin
            chk("hold_gap1", acc_cyc[1] - acc_cyc[0], 14);
            chk("hold_gap2", acc_cyc[2] - acc_cyc[1], 14);
        end

        // coefficient write while busy is ignored
        do_reset();
        accept(50);
        chk("busy_ready", in_ready, 0);
        coef_we = 1; coef_addr = 4'd0; coef_wdata = 16'sd16384;
        step();
        coef_we = 0;
        drain();
        chk("busy_write_out", last_out, 50);
        send(50); chk("busy_write_ignored", last_out, 50);

        // out-of-range coefficient address is ignored
        wcoef(12, 1000);
        send(20); chk("bad_addr", last_out, 20);

        // reset mid-MAC
        do_reset();
        wcoef(0, 2048);
        send(-77); chk("half_gain", last_out, -38);
        accept(60);
        step(); step();
        rst = 1; step(); rst = 0;
        n = n_out;
        for (int i = 0; i < 20; i++) step();
        chk("rst_no_out", n_out, n);
        send(-77); chk("rst_passthrough", last_out, -77);

        // randomized coefficients and samples against the model
        do_reset();
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                int a, v;
                a = int'($urandom_range(0, 15));
                if (a % 5 < 3) v = int'($urandom_range(0, 12000)) - 6000;
                else v = int'($urandom_range(0, 6000)) - 3000;
                wcoef(a, v);
            end
            send(int'($urandom_range(0, 255)) - 128);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
